// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Purpose:
//   Accepts one memory request at a time and completes it against a
//   single-port synchronous RAM (one-cycle read latency). Every output is
//   registered. Requests whose byte address lies beyond the RAM are rejected
//   without touching the RAM. They complete one cycle after they are sampled,
//   with err=1.
//
// Parameters:
//   ADDR_W      RAM word-address width (default 14)
//   WAIT_CYCLES cycles from RAM address issue to read-data capture (1..15)
//
// Optional build macro:
//   MEM_ALIGN_CHECK_EN  when defined, byte addresses with [1:0] != 0 are
//                       rejected in the same way as out-of-range ones.
//
// Ports:
//   clk        in   clock; all state updates on its rising edge
//   reset_n    in   synchronous active-low reset
//   req        in   requester asks for one access (sampled only in IDLE)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   32-bit byte address
//   req_wdata  in   32-bit write data
//   ack        out  one-cycle completion pulse
//   err        out  qualifies ack: the access was rejected
//   rdata      out  read result, valid while ack=1 for reads
//   busy       out  high whenever the FSM is not in IDLE
//   ram_addr   out  RAM word address
//   ram_wdata  out  RAM write data
//   ram_wren   out  RAM write strobe
//   ram_q      in   RAM read data
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              ack,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wren,
    input  logic [31:0]       ram_q
);

    // state | meaning
    // IDLE  | waiting for req; rejected requests jump straight to RESP
    // ISSUE | address/data on the RAM port, write strobe for one cycle
    // WAIT  | counting down WAIT_CYCLES; ram_q captured on the last cycle
    // RESP  | ack pulse (err set for rejected requests)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_we;
    logic               r_ack;
    logic               r_err;
    logic               r_busy;
    logic [31:0]        r_rdata;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [31:0]        r_ram_wdata;
    logic               r_ram_wren;

    state_t             w_state_nxt;
    logic [3:0]         w_cnt_nxt;
    logic               w_we_nxt;
    logic               w_ack_nxt;
    logic               w_err_nxt;
    logic [31:0]        w_rdata_nxt;
    logic [ADDR_W-1:0]  w_ram_addr_nxt;
    logic [31:0]        w_ram_wdata_nxt;
    logic               w_ram_wren_nxt;
    logic               w_out_of_range;
    logic               w_reject;

    // Any set bit above the RAM's byte-address span means the access misses the RAM.
    assign w_out_of_range = |(req_addr >> (ADDR_W + 2));

`ifdef MEM_ALIGN_CHECK_EN
    assign w_reject = w_out_of_range | (req_addr[1:0] != 2'b00);
`else
    assign w_reject = w_out_of_range;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_rdata     <= 32'd0;
            r_ram_addr  <= '0;
            r_ram_wdata <= 32'd0;
            r_ram_wren  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_we        <= w_we_nxt;
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_rdata     <= w_rdata_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_ram_wren  <= w_ram_wren_nxt;
        end
    end

    // Next-state and next-output values; the outputs are registered above so
    // each one takes effect in the state it belongs to.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_we_nxt        = r_we;
        w_ack_nxt       = 1'b0;
        w_err_nxt       = 1'b0;
        w_rdata_nxt     = r_rdata;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_ram_wren_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_reject) begin
                        w_state_nxt = RESP;
                        w_ack_nxt   = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt     = ISSUE;
                        w_we_nxt        = req_we;
                        w_ram_addr_nxt  = req_addr[ADDR_W+1:2];
                        w_ram_wdata_nxt = req_wdata;
                        w_ram_wren_nxt  = req_we;
                    end
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = LP_WAIT;
            end
            WAIT: begin
                // Terminal count at 1: the count is loaded on entry, so a load
                // of N gives exactly N cycles in WAIT.
                if (r_cnt == 4'd1) begin
                    w_state_nxt = RESP;
                    w_cnt_nxt   = 4'd0;
                    w_ack_nxt   = 1'b1;
                    if (!r_we) begin
                        w_rdata_nxt = ram_q;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_wren  = r_ram_wren;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Scoreboard bench for mem_responder (default parameters). The stimulus
// process drives requests. For each request it asks a behavioural reference
// model for the expected outcome and queues it:
//   - the expected ack: cycle, err and rdata;
//   - the expected RAM write strobe: cycle, word address and data.
// A negedge monitor pops these queues whenever the DUT shows ack or ram_wren.
// The stimulus process requests reset, timeout and end-of-run checks through
// chk_kind, and the monitor carries them out. Only the monitor changes the
// counters.
// A behavioural RAM with a preload port stands in for the memory.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int TB_AW   = 14;
    localparam int TB_WAIT = 1;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic        req;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        busy;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wren;
    logic [31:0] ram_q;

    logic        pl_en;
    logic [13:0] pl_addr;
    logic [31:0] pl_data;

    logic [31:0] mem     [0:(1<<TB_AW)-1];
    logic [31:0] ref_mem [0:(1<<TB_AW)-1];
    logic [31:0] ref_rdata;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int chk_kind = 0;

    mem_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wren  (ram_wren),
        .ram_q     (ram_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    // Reference model. It records what the request should do and what it
    // should return, and queues the expectations.
    // c is the cycle in which req is first presented to an idle responder.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int c, input bit push_ack);
        bit   rej;
        int   word;
        exp_t e;
        wr_t  w;
        rej = ((addr >> (TB_AW + 2)) != 0);
`ifdef MEM_ALIGN_CHECK_EN
        rej = rej || (addr[1:0] != 2'b00);
`endif
        word = int'((addr >> 2) & ((1 << TB_AW) - 1));
        if (rej) begin
            e.cyc   = c + 1;
            e.err   = 1'b1;
            e.rdata = ref_rdata;
        end else begin
            if (we) begin
                ref_mem[word] = wdata;
                w.cyc  = c + 1;
                w.addr = word[13:0];
                w.data = wdata;
                wr_q.push_back(w);
            end else begin
                ref_rdata = ref_mem[word];
            end
            e.cyc   = c + 2 + TB_WAIT;
            e.err   = 1'b0;
            e.rdata = ref_rdata;
        end
        if (push_ack) exp_q.push_back(e);
    endtask

    // Monitor: the only place where comparisons are made and counted.
    always @(negedge clk) begin : monitor
        exp_t e;
        wr_t  w;
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ack_unexpected cycle=%0d err=%b rdata=%h", cyc, err, rdata);
            end else begin
                e = exp_q.pop_front();
                checks += 3;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL ack_cycle got=%0d exp=%0d", cyc, e.cyc);
                end
                if (err !== e.err) begin
                    errors++;
                    $display("FAIL ack_err cycle=%0d got=%b exp=%b", cyc, err, e.err);
                end
                if (rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL ack_rdata cycle=%0d got=%h exp=%h", cyc, rdata, e.rdata);
                end
            end
        end
        checks++;
        if (err === 1'b1 && ack !== 1'b1) begin
            errors++;
            $display("FAIL err_without_ack cycle=%0d got err=%b ack=%b exp err=0", cyc, err, ack);
        end
        if (ram_wren === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL wren_unexpected cycle=%0d addr=%h data=%h", cyc, ram_addr, ram_wdata);
            end else begin
                w = wr_q.pop_front();
                checks += 3;
                if (cyc != w.cyc) begin
                    errors++;
                    $display("FAIL wren_cycle got=%0d exp=%0d", cyc, w.cyc);
                end
                if (ram_addr !== w.addr) begin
                    errors++;
                    $display("FAIL wren_addr got=%h exp=%h", ram_addr, w.addr);
                end
                if (ram_wdata !== w.data) begin
                    errors++;
                    $display("FAIL wren_data got=%h exp=%h", ram_wdata, w.data);
                end
            end
        end
        case (chk_kind)
            1: begin
                checks++;
                if ({ack, err, busy, ram_wren} !== 4'b0000 || rdata !== 32'd0 ||
                    ram_addr !== 14'd0 || ram_wdata !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_state got ack=%b err=%b busy=%b wren=%b rdata=%h addr=%h wdata=%h exp all zero",
                             ack, err, busy, ram_wren, rdata, ram_addr, ram_wdata);
                end
            end
            2: begin
                checks++; errors++;
                $display("FAIL busy_timeout cycle=%0d got busy=%b exp busy=0 within budget", cyc, busy);
            end
            3: begin
                checks += 2;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL acks_missing got=%0d pending exp=0", exp_q.size());
                end
                if (wr_q.size() != 0) begin
                    errors++;
                    $display("FAIL writes_missing got=%0d pending exp=0", wr_q.size());
                end
            end
            default: ;
        endcase
    end

    // Ask the monitor to carry out a check at the next negedge.
    task automatic request_check(input int kind);
        @(posedge clk);
        chk_kind = kind;
        @(negedge clk);
        #1 chk_kind = 0;
    endtask

    // Present one request for a single cycle, then wait until the responder
    // is idle again. Called at a negedge with the responder idle.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        req = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        model(we, addr, wdata, cyc, 1'b1);
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) request_check(2);
    endtask

    initial begin : stim
        int          c;
        int          r;
        int          word;
        logic [31:0] addr;
        reset_n = 1'b0;
        req = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        pl_en = 1'b0; pl_addr = 14'd0; pl_data = 32'd0;
        ref_rdata = 32'd0;

        // Preload words 0..31 during reset; word 0x10 holds 0xDEADBEEF.
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            pl_en = 1'b1;
            pl_addr = 14'(i);
            pl_data = (i == 16) ? 32'hDEAD_BEEF : $urandom;
            ref_mem[i] = pl_data;
            @(negedge clk);
        end
        pl_en = 1'b0;
        request_check(1);
        reset_n = 1'b1;
        @(negedge clk);

        // Read word 0x10.
        issue(1'b0, 32'h0000_0040, 32'h0);
        // Write 0x44, then read it back.
        issue(1'b1, 32'h0000_0044, 32'h1234_5678);
        issue(1'b0, 32'h0000_0044, 32'h0);

        // req held high for 8 cycles gives two accesses, acks 4 cycles apart.
        c = cyc;
        req = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040; req_wdata = 32'h0;
        model(1'b0, 32'h0000_0040, 32'h0, c, 1'b1);
        model(1'b0, 32'h0000_0040, 32'h0, c + 4, 1'b1);
        repeat (8) @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);

        // Out-of-range write: rejected, no RAM write, rdata unchanged.
        issue(1'b1, 32'h0001_0000, 32'hFFFF_FFFF);
        // Misaligned read of word 0x10.
        issue(1'b0, 32'h0000_0042, 32'h0);

        // Reset while the write is in ISSUE. The strobe for that cycle still
        // reaches the RAM, but no ack follows.
        req = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0048; req_wdata = 32'hCAFE_F00D;
        model(1'b1, 32'h0000_0048, 32'hCAFE_F00D, cyc, 1'b0);
        @(negedge clk);
        req = 1'b0;
        reset_n = 1'b0;
        ref_rdata = 32'd0;
        request_check(1);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        issue(1'b0, 32'h0000_0048, 32'h0);

        // Randomized mix of reads, writes, out-of-range and misaligned requests.
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            word = $urandom_range(0, 31);
            if (r == 0) addr = $urandom | 32'h0001_0000;
            else if (r == 1) addr = (32'(word) << 2) | 32'($urandom_range(1, 3));
            else addr = 32'(word) << 2;
            issue(1'($urandom_range(0, 1)), addr, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        request_check(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning RAM word-address width.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning cycles from RAM address issue to read-data capture (legal 1..15).
REQ-003 SHALL have port clk input 1: clock, all state updates on its rising edge.
REQ-004 SHALL have port reset_n input 1: reset, synchronous, active-low.
REQ-005 SHALL have port req input 1: requester asks for one memory access.
REQ-006 SHALL have port req_we input 1: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr input 32: byte address.
REQ-008 SHALL have port req_wdata input 32: write data.
REQ-009 SHALL have port ack output 1: one-cycle completion pulse.
REQ-010 SHALL have port err output 1: qualifies ack; access was rejected.
REQ-011 SHALL have port rdata output 32: read result, valid while ack=1 for reads.
REQ-012 SHALL have port busy output 1: high whenever state is not IDLE.
REQ-013 SHALL have port ram_addr output ADDR_W: RAM word address.
REQ-014 SHALL have port ram_wdata output 32: RAM write data.
REQ-015 SHALL have port ram_wren output 1: RAM write strobe.
REQ-016 SHALL have port ram_q input 32: RAM read data, one-cycle synchronous latency.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-018 SHALL, in IDLE with req=1, latch req_we, req_addr, req_wdata and go to ISSUE; with req=0, stay in IDLE.
REQ-019 SHALL, in ISSUE, drive ram_addr=req_addr[ADDR_W+1:2], ram_wdata=latched data, ram_wren=latched we for exactly one cycle, then go to WAIT.
REQ-020 SHALL hold ram_addr stable from ISSUE through the last WAIT cycle; ram_wren=0 in every state except ISSUE.
REQ-021 SHALL remain in WAIT for exactly WAIT_CYCLES cycles using a 4-bit down-counter; on a read, ram_q is captured into rdata at the end of the last WAIT cycle.
REQ-022 SHALL assert ack=1 for exactly one cycle in RESP, then return to IDLE.
REQ-023 SHALL give a request sampled in cycle 0 its ack in cycle 2+WAIT_CYCLES (cycle 3 at default).
REQ-024 SHALL leave rdata unchanged on writes and on rejected accesses.
REQ-025 SHALL reject as out-of-range, with no RAM access, any request where req_addr[31:ADDR_W+2] is non-zero: IDLE->RESP directly, ack=1, err=1, for a latency of 1 cycle.
REQ-026 SHALL ignore req outside IDLE; req still high in the IDLE cycle after RESP starts a new access (back-to-back allowed, no bubble beyond IDLE).
REQ-027 SHALL drive err=0 whenever ack=0.

Reset
REQ-028 SHALL, when reset_n=0 at a clock edge, go to IDLE and set ack=0, err=0, busy=0, ram_wren=0, ram_addr=0, ram_wdata=0, rdata=0, wait counter=0.
REQ-029 SHALL, on reset in any state (including ISSUE), abort the access with no ack, and never emit a write strobe on the cycle after reset.

Configuration
REQ-030 SHALL, with macro MEM_ALIGN_CHECK_EN defined, reject any request with req_addr[1:0] != 0 exactly like an out-of-range access (no RAM access, ack=1 and err=1 one cycle later).
REQ-031 SHALL, without MEM_ALIGN_CHECK_EN, ignore req_addr[1:0], so that only the range check can raise err.

Verification
REQ-032 SHALL cover a read: RAM word 0x10 = 0xDEADBEEF, req at addr 0x40, we=0 -> ram_wren stays 0, ack in cycle 3, rdata=0xDEADBEEF, err=0.
REQ-033 SHALL cover a write followed by a read: write 0x12345678 to addr 0x44 -> single ram_wren pulse with ram_addr=0x11; then read 0x44 -> rdata=0x12345678.
REQ-034 SHALL cover back-to-back requests: req held high for 8 cycles, WAIT_CYCLES=1 -> two acks, at cycles 3 and 7.
REQ-035 SHALL cover an out-of-range access: req_addr=0x0001_0000, ADDR_W=14 -> ack=1 and err=1 in cycle 1, no ram_wren, rdata unchanged.
REQ-036 SHALL cover a misaligned access: req_addr=0x42; with MEM_ALIGN_CHECK_EN -> err=1 in cycle 1; without it -> normal access to word 0x10.
REQ-037 SHALL cover reset mid-access: write request, reset_n=0 during ISSUE -> ack never asserted, busy=0 and ram_wren=0 after the reset edge.
